lsu: RTL and testbench

Load/store unit for the single-issue RV32I core. It sits directly downstream of the ALU: the ALU result is the effective address, and rs2 is the store data. The unit performs one data-memory transaction per accepted request through a valid/ack memory port. It handles byte-lane alignment, store lane replication and load sign/zero extension, then returns a one-cycle response to the writeback stage.

---
 rtl/lsu.sv | 196 +++++++++++++++++++
 tb/tb_lsu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory transaction per accepted request,
// with byte-lane steering on stores and sign/zero extension on loads.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_dmtype,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic        rsp_wb,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_exc
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  dmtype_q, dmtype_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [4:0]  rd_q, rd_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_wb_q, rsp_wb_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_exc_q, rsp_exc_d;

  logic [1:0]  exc_in;

  // Illegal encodings win over misalignment.
  function automatic logic [1:0] classify(input logic [2:0] dm, input logic [1:0] lo);
    case (dm)
      3'b011, 3'b110, 3'b111: classify = 2'b10;
      3'b001, 3'b101:         classify = lo[0] ? 2'b01 : 2'b00;
      3'b010:                 classify = (lo != 2'b00) ? 2'b01 : 2'b00;
      default:                classify = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] dm, input logic [1:0] lo);
    case (dm[1:0])
      2'b00:   store_be = 4'b0001 << lo;
      2'b01:   store_be = lo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] dm, input logic [31:0] d);
    case (dm[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] dm, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rdata[{lo, 3'b000} +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (dm)
      3'b000:  load_ext = 32'(b);
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = 32'(h);
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = rdata;
    endcase
  endfunction

  assign exc_in = classify(req_dmtype, req_addr[1:0]);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    dmtype_d    = dmtype_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_wb_d    = 1'b0;
    rsp_rd_d    = 5'd0;
    rsp_rdata_d = 32'd0;
    rsp_exc_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          dmtype_d  = req_dmtype;
          addr_lo_d = req_addr[1:0];
          rd_d      = req_rd;
          if (exc_in != 2'b00) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rd_d    = req_rd;
            rsp_exc_d   = exc_in;
          end else begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = req_we ? store_be(req_dmtype, req_addr[1:0]) : 4'b1111;
            mem_wdata_d = req_we ? store_data(req_dmtype, req_wdata) : 32'd0;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_be_d    = 4'd0;
          mem_wdata_d = 32'd0;
          rsp_valid_d = 1'b1;
          rsp_wb_d    = ~we_q;
          rsp_rd_d    = rd_q;
          rsp_rdata_d = we_q ? 32'd0 : load_ext(dmtype_q, addr_lo_q, mem_rdata);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_wb_q    <= 1'b0;
      rsp_rd_q    <= 5'd0;
      rsp_rdata_q <= 32'd0;
      rsp_exc_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wb_q    <= rsp_wb_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_exc_q   <= rsp_exc_d;
    end
  end

  // Request fields are only consumed after the FSM leaves IDLE, so they carry no reset.
  always_ff @(posedge clk) begin
    we_q      <= we_d;
    dmtype_q  <= dmtype_d;
    addr_lo_q <= addr_lo_d;
    rd_q      <= rd_d;
  end

  assign req_ready = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wb    = rsp_wb_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_exc   = rsp_exc_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: table of single ops plus hand sequences for
// long ack waits, stray acks and reset in the middle of an access.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_dmtype;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_wb;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_exc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_dmtype(req_dmtype), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_wb(rsp_wb), .rsp_rd(rsp_rd),
    .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc)
  );

  typedef struct {
    logic        we;
    logic [2:0]  dm;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          k;
    logic [1:0]  exc;
    logic [3:0]  be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] dm, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                     input int k, input logic [1:0] exc, input logic [3:0] be,
                     input logic [31:0] exp_wd, input logic [31:0] exp_rdata);
    vec_t v;
    v.we = we; v.dm = dm; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
    v.k = k; v.exc = exc; v.be = be; v.exp_wd = exp_wd; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endtask

  // Entered and left just after a falling edge with the unit idle.
  task automatic run_op(input vec_t v);
    logic [31:0] waddr;
    waddr = {v.addr[31:2], 2'b00};
    chk("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_dmtype = v.dm; req_addr = v.addr;
    req_wdata = v.wdata; req_rd = v.rd;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.exc != 2'b00) begin
      chk("exc_mem_req", 32'(mem_req), 32'd0);
      chk("exc_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("exc_code", 32'(rsp_exc), 32'(v.exc));
      chk("exc_wb", 32'(rsp_wb), 32'd0);
      chk("exc_rd", 32'(rsp_rd), 32'(v.rd));
      chk("exc_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      chk("exc_rsp_drop", 32'(rsp_valid), 32'd0);
      chk("exc_ready_back", 32'(req_ready), 32'd1);
    end else begin
      for (int i = 1; i <= v.k; i++) begin
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_we", 32'(mem_we), 32'(v.we));
        chk("mem_addr", mem_addr, waddr);
        chk("mem_be", 32'(mem_be), 32'(v.be));
        if (v.we) chk("mem_wdata", mem_wdata, v.exp_wd);
        chk("ready_busy", 32'(req_ready), 32'd0);
        chk("rsp_idle", 32'(rsp_valid), 32'd0);
        mem_ack = (i == v.k);
        mem_rdata = v.rdata;
        @(negedge clk);
      end
      mem_ack = 1'b0;
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("mem_req_drop", 32'(mem_req), 32'd0);
      chk("mem_be_zero", 32'(mem_be), 32'd0);
      chk("rsp_exc", 32'(rsp_exc), 32'd0);
      chk("rsp_wb", 32'(rsp_wb), 32'(!v.we));
      chk("rsp_rd", 32'(rsp_rd), 32'(v.rd));
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      @(negedge clk);
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
      chk("rsp_rdata_zero", rsp_rdata, 32'd0);
      chk("ready_back", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_dmtype = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    //     we  dm      addr           wdata          rd     rdata          k  exc    be       exp_wd         exp_rdata
    add(1'b1, 3'b010, 32'h0000_0100, 32'h1234_5678, 5'd1,  32'h0,         1, 2'b00, 4'b1111, 32'h1234_5678, 32'h0);
    add(1'b0, 3'b010, 32'h0000_0100, 32'h0,         5'd5,  32'h1234_5678, 1, 2'b00, 4'b1111, 32'h0,         32'h1234_5678);
    add(1'b1, 3'b000, 32'h0000_0103, 32'h0000_0080, 5'd2,  32'h0,         1, 2'b00, 4'b1000, 32'h8080_8080, 32'h0);
    add(1'b0, 3'b000, 32'h0000_0103, 32'h0,         5'd6,  32'h8000_0000, 2, 2'b00, 4'b1111, 32'h0,         32'hFFFF_FF80);
    add(1'b0, 3'b100, 32'h0000_0103, 32'h0,         5'd7,  32'h8000_0000, 1, 2'b00, 4'b1111, 32'h0,         32'h0000_0080);
    add(1'b0, 3'b001, 32'h0000_0102, 32'h0,         5'd8,  32'h8001_ABCD, 1, 2'b00, 4'b1111, 32'h0,         32'hFFFF_8001);
    add(1'b0, 3'b101, 32'h0000_0100, 32'h0,         5'd9,  32'h8001_ABCD, 3, 2'b00, 4'b1111, 32'h0,         32'h0000_ABCD);
    add(1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 5'd3,  32'h0,         1, 2'b00, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    add(1'b1, 3'b001, 32'h0000_0100, 32'hAAAA_1234, 5'd3,  32'h0,         1, 2'b00, 4'b0011, 32'h1234_1234, 32'h0);
    add(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 5'd4,  32'h0,         2, 2'b00, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    add(1'b0, 3'b000, 32'h0000_0101, 32'h0,         5'd10, 32'h0000_7F00, 1, 2'b00, 4'b1111, 32'h0,         32'h0000_007F);
    add(1'b0, 3'b001, 32'h0000_0100, 32'h0,         5'd11, 32'h0000_7FFF, 1, 2'b00, 4'b1111, 32'h0,         32'h0000_7FFF);
    add(1'b0, 3'b101, 32'h0000_0102, 32'h0,         5'd12, 32'h8001_ABCD, 1, 2'b00, 4'b1111, 32'h0,         32'h0000_8001);
    add(1'b0, 3'b001, 32'h0000_0101, 32'h0,         5'd13, 32'h0,         1, 2'b01, 4'b0000, 32'h0,         32'h0);
    add(1'b1, 3'b010, 32'h0000_0102, 32'h0,         5'd14, 32'h0,         1, 2'b01, 4'b0000, 32'h0,         32'h0);
    add(1'b0, 3'b011, 32'h0000_0101, 32'h0,         5'd15, 32'h0,         1, 2'b10, 4'b0000, 32'h0,         32'h0);
    add(1'b0, 3'b110, 32'h0000_0100, 32'h0,         5'd16, 32'h0,         1, 2'b10, 4'b0000, 32'h0,         32'h0);
    add(1'b1, 3'b111, 32'h0000_0100, 32'h0,         5'd17, 32'h0,         1, 2'b10, 4'b0000, 32'h0,         32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_wb", 32'(rsp_wb), 32'd0);
    chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_exc", 32'(rsp_exc), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i]);

    // LW with a 4-cycle ack wait while upstream keeps presenting another op.
    req_valid = 1'b1; req_we = 1'b0; req_dmtype = 3'b010; req_addr = 32'h0000_0200; req_rd = 5'd7;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h0000_0300; req_wdata = 32'hDEAD_BEEF; req_rd = 5'd20;
    for (int i = 1; i <= 4; i++) begin
      chk("wait_mem_req", 32'(mem_req), 32'd1);
      chk("wait_mem_addr", mem_addr, 32'h0000_0200);
      chk("wait_mem_we", 32'(mem_we), 32'd0);
      chk("wait_mem_be", 32'(mem_be), 32'hF);
      chk("wait_ready", 32'(req_ready), 32'd0);
      mem_ack = (i == 4); mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    req_valid = 1'b0;
    chk("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wait_rsp_rd", 32'(rsp_rd), 32'd7);
    chk("wait_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    chk("wait_ready_rsp", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("wait_ready_back", 32'(req_ready), 32'd1);
    chk("wait_no_second", 32'(mem_req), 32'd0);

    // Stray acks while idle.
    mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_rsp", 32'(rsp_valid), 32'd0);
      chk("stray_mem_req", 32'(mem_req), 32'd0);
      chk("stray_ready", 32'(req_ready), 32'd1);
    end
    mem_ack = 1'b0;

    // Reset in the middle of an access.
    req_valid = 1'b1; req_we = 1'b1; req_dmtype = 3'b010; req_addr = 32'h0000_0400;
    req_wdata = 32'h1111_2222; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    mem_ack = 1'b0;
    run_op(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
